// File: rtl/sc2110_deserial_unpack_module.sv
// SC2110 LVDS receive lane unpacker: buffers CHxBW deserialised words in a small FIFO
// and streams the de-interleaved pixels out one per clock with first/last markers.
module sc2110_deserial_unpack_module #(
   parameter int CH    = 4,
   parameter int BW    = 12,
   parameter int DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_dvld,
   input  logic [CH*BW-1:0] i_data,
   input  logic             i_order,
   input  logic             i_clr_ovf,
   output logic [BW-1:0]    o_data,
   output logic             o_dvld,
   output logic             o_first,
   output logic             o_last,
   output logic             o_busy,
   output logic             o_ovf
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int BTW = $clog2(CH);
   localparam int WW  = CH * BW;

   localparam logic [0:0]     ST_IDLE   = 1'b0;
   localparam logic [0:0]     ST_EMIT   = 1'b1;
   localparam logic [BTW-1:0] LAST_BEAT = BTW'(CH - 1);

   logic [WW-1:0]         mem [DEPTH];
   logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
   logic [0:0]            state_reg;
   logic [BTW-1:0]        beat_reg;
   logic [WW-1:0]         unpack_reg;
   logic                  order_reg;

   logic                  empty, full, pop, push, drop;
   logic [WW-1:0]         head_word, src_word;
   logic                  order_next;
   logic [BTW-1:0]        beat_inc, beat_next, sel_ch;
   logic [CH-1:0][BW-1:0] chan_pix;
   logic [BW-1:0]         pix_next;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   // Reload happens from IDLE or straight after the last beat, so words chain without a bubble.
   assign pop  = !empty && ((state_reg == ST_IDLE) || (beat_reg == LAST_BEAT));
   assign push = i_dvld && (!full || pop);
   assign drop = i_dvld && full && !pop;

   assign head_word  = mem[rd_ptr_reg[AW-1:0]];
   assign src_word   = pop ? head_word : unpack_reg;
   assign order_next = pop ? i_order : order_reg;
   assign beat_inc   = beat_reg + BTW'(1);
   assign beat_next  = pop ? '0 : beat_inc;
   assign sel_ch     = order_next ? beat_next : (LAST_BEAT - beat_next);

   genvar gi, gj;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         for (gj = 0; gj < BW; gj++) begin : g_bit
            assign chan_pix[gi][gj] = src_word[gj*CH + gi];
         end
      end
   endgenerate

   assign pix_next = chan_pix[sel_ch];
   assign o_busy   = !empty || (state_reg == ST_EMIT) || o_dvld;

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr_reg[AW-1:0]] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         state_reg  <= ST_IDLE;
         beat_reg   <= '0;
         unpack_reg <= '0;
         order_reg  <= 1'b0;
         o_data     <= '0;
         o_dvld     <= 1'b0;
         o_first    <= 1'b0;
         o_last     <= 1'b0;
         o_ovf      <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);

         if (drop)           o_ovf <= 1'b1;
         else if (i_clr_ovf) o_ovf <= 1'b0;

         // Beat 0 is driven from the FIFO head in the same edge that pops it.
         if (pop) begin
            unpack_reg <= head_word;
            order_reg  <= i_order;
            beat_reg   <= '0;
            state_reg  <= ST_EMIT;
            o_data     <= pix_next;
            o_dvld     <= 1'b1;
            o_first    <= 1'b1;
            o_last     <= 1'b0;
         end else if ((state_reg == ST_EMIT) && (beat_reg != LAST_BEAT)) begin
            beat_reg   <= beat_inc;
            o_data     <= pix_next;
            o_dvld     <= 1'b1;
            o_first    <= 1'b0;
            o_last     <= (beat_inc == LAST_BEAT);
         end else begin
            state_reg  <= ST_IDLE;
            o_data     <= '0;
            o_dvld     <= 1'b0;
            o_first    <= 1'b0;
            o_last     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sc2110_deserial_unpack_module.sv
// Directed bench for the SC2110 lane unpacker: a CH=4/BW=12 instance and a CH=8/BW=10 instance.
module tb_sc2110_deserial_unpack_module;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, dvld, order, clr;
   logic [47:0] data;
   logic [11:0] o_data;
   logic        o_dvld, o_first, o_last, o_busy, o_ovf;

   logic        dvld8, order8, clr8;
   logic [79:0] data8;
   logic [9:0]  o_data8;
   logic        o_dvld8, o_first8, o_last8, o_busy8, o_ovf8;

   sc2110_deserial_unpack_module #(.CH(4), .BW(12), .DEPTH(2)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_dvld(dvld), .i_data(data), .i_order(order),
      .i_clr_ovf(clr), .o_data(o_data), .o_dvld(o_dvld), .o_first(o_first),
      .o_last(o_last), .o_busy(o_busy), .o_ovf(o_ovf));

   sc2110_deserial_unpack_module #(.CH(8), .BW(10), .DEPTH(2)) dut8 (
      .i_clk(clk), .i_rstn(rstn), .i_dvld(dvld8), .i_data(data8), .i_order(order8),
      .i_clr_ovf(clr8), .o_data(o_data8), .o_dvld(o_dvld8), .o_first(o_first8),
      .o_last(o_last8), .o_busy(o_busy8), .o_ovf(o_ovf8));

   int n_vec = 0;
   int n_err = 0;
   logic [11:0] cap_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      tick();
      if (o_dvld) cap_q.push_back(o_data);
   endtask

   function automatic logic [47:0] pack4(input logic [3:0][11:0] p);
      logic [47:0] w;
      w = '0;
      for (int c = 0; c < 4; c++)
         for (int b = 0; b < 12; b++) w[b*4 + c] = p[c][b];
      return w;
   endfunction

   function automatic logic [79:0] pack8(input logic [7:0][9:0] p);
      logic [79:0] w;
      w = '0;
      for (int c = 0; c < 8; c++)
         for (int b = 0; b < 10; b++) w[b*8 + c] = p[c][b];
      return w;
   endfunction

   function automatic logic [11:0] pix(input int i, input int c);
      return 12'((i << 8) | (c << 4) | 5);
   endfunction

   function automatic logic [47:0] make_word(input int i);
      logic [3:0][11:0] p;
      for (int c = 0; c < 4; c++) p[c] = pix(i, c);
      return pack4(p);
   endfunction

   initial begin
      logic [11:0]      e4 [4];
      logic [7:0][9:0]  w8;
      int               ndv;
      int               now;

      rstn = 1'b0; dvld = 1'b0; order = 1'b0; clr = 1'b0; data = '0;
      dvld8 = 1'b0; order8 = 1'b0; clr8 = 1'b0; data8 = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_data",  32'(o_data), 32'h0);
      chk("rst_dvld",  32'(o_dvld), 32'h0);
      chk("rst_flags", {29'h0, o_first, o_last, o_busy}, 32'h0);
      chk("rst_ovf",   32'(o_ovf),  32'h0);
      @(negedge clk) rstn = 1'b1;
      tick();

      // Single word, order 0
      e4 = '{12'hABC, 12'h789, 12'h456, 12'h123};
      data = pack4({12'hABC, 12'h789, 12'h456, 12'h123});
      order = 1'b0; dvld = 1'b1;
      tick();
      dvld = 1'b0;
      chk("o0_busy_queued", 32'(o_busy), 32'h1);
      chk("o0_no_early_dvld", 32'(o_dvld), 32'h0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("o0_beat%0d", k), {17'h0, o_dvld, o_first, o_last, o_data},
             {17'h0, 1'b1, (k == 0), (k == 3), e4[k]});
         tick();
      end
      chk("o0_after", {18'h0, o_dvld, o_busy, o_data}, 32'h0);

      // Order 1 with i_order toggled back while the word is in flight
      e4 = '{12'h123, 12'h456, 12'h789, 12'hABC};
      order = 1'b1; dvld = 1'b1;
      tick();
      dvld = 1'b0;
      tick();
      order = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("o1_beat%0d", k), {17'h0, o_dvld, o_first, o_last, o_data},
             {17'h0, 1'b1, (k == 0), (k == 3), e4[k]});
         tick();
      end

      // Sustained stream: one word every 4 cycles, 10 words
      ndv = 0;
      for (int cyc = 0; cyc < 44; cyc++) begin
         dvld = ((cyc % 4) == 0) && (cyc < 40);
         data = make_word(cyc / 4);
         tick();
         now = cyc + 1;
         if (o_dvld) ndv++;
         if (now >= 2 && now <= 41)
            chk($sformatf("stream_w%0d_b%0d", (now - 2) / 4, (now - 2) % 4),
                {19'h0, o_dvld, o_data}, {19'h0, 1'b1, pix((now - 2) / 4, 3 - ((now - 2) % 4))});
      end
      dvld = 1'b0;
      chk("stream_count", 32'(ndv), 32'd40);
      chk("stream_ovf", 32'(o_ovf), 32'h0);
      chk("stream_idle", 32'(o_busy), 32'h0);

      // Five back-to-back strobes: three words survive, two are dropped
      cap_q.delete();
      for (int i = 0; i < 5; i++) begin
         dvld = 1'b1; data = make_word(20 + i);
         step();
      end
      dvld = 1'b0;
      repeat (16) step();
      chk("ovf_beats", 32'(cap_q.size()), 32'd12);
      for (int j = 0; j < 12; j++)
         if (j < cap_q.size())
            chk($sformatf("ovf_pix%0d", j), 32'(cap_q[j]), 32'(pix(20 + j / 4, 3 - (j % 4))));
      chk("ovf_set", 32'(o_ovf), 32'h1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("ovf_clear", 32'(o_ovf), 32'h0);

      // Drop coincides with a clear request: set wins
      for (int i = 0; i < 5; i++) begin
         dvld = 1'b1; data = make_word(40 + i); clr = (i == 3);
         step();
         if (i == 3) chk("ovf_set_vs_clr", 32'(o_ovf), 32'h1);
      end
      dvld = 1'b0; clr = 1'b0;
      repeat (16) step();

      // Asynchronous reset during beat 2 with a second word queued
      order = 1'b0; dvld = 1'b1; data = make_word(30);
      tick();
      data = make_word(31);
      tick();
      dvld = 1'b0;
      tick();
      tick();
      chk("rstmid_beat2", {19'h0, o_dvld, o_data}, {19'h0, 1'b1, pix(30, 1)});
      #2 rstn = 1'b0;
      #1;
      chk("rstmid_data", 32'(o_data), 32'h0);
      chk("rstmid_flags", {28'h0, o_dvld, o_first, o_last, o_busy}, 32'h0);
      chk("rstmid_ovf", 32'(o_ovf), 32'h0);
      @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      ndv = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (o_dvld || o_busy) ndv++;
      end
      chk("rstmid_quiet", 32'(ndv), 32'h0);

      // CH=8, BW=10: walking one per channel, both orders
      for (int c = 0; c < 8; c++) w8[c] = 10'(1 << c);
      for (int ord = 0; ord < 2; ord++) begin
         data8 = pack8(w8); order8 = ord[0]; dvld8 = 1'b1;
         tick();
         dvld8 = 1'b0;
         tick();
         for (int k = 0; k < 8; k++) begin
            chk($sformatf("ch8_o%0d_b%0d", ord, k),
                {19'h0, o_dvld8, o_first8, o_last8, o_data8},
                {19'h0, 1'b1, (k == 0), (k == 7), 10'(1 << ((ord == 1) ? k : 7 - k))});
            tick();
         end
         chk($sformatf("ch8_o%0d_idle", ord), {30'h0, o_dvld8, o_busy8}, 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
